// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer
//
// Initiator-side driver for the RSA `control` core. Accepts one job (p, q, mode, message)
// on a valid/ready channel, registers the operands onto the core inputs, sequences the
// core's reset_inverter / reset_mod_exp pulses, waits on the matching finish flags and
// returns the captured msg_out on a valid/ready result channel with an error code.
//
// Optional feature (compile-time macro RSA_ROUNDTRIP_CHECK_EN): for encrypt jobs a second
// decrypt pass is run on the ciphertext and compared with the original message.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   job_valid / job_ready      job handshake; job_p, job_q, job_mode, job_msg operands
//   res_valid / res_ready      result handshake; res_data result, res_err status
//                              (00 ok, 01 timeout, 10 round-trip mismatch)
//   core_p, core_q, core_mode, core_msg      operands to the control core
//   core_reset_inverter, core_reset_mod_exp  one-cycle reset pulses to the control core
//   core_inverter_finish, core_mod_exp_finish, core_msg_out  status/result from the core

module rsa_job_sequencer #(
    parameter int unsigned WIDTH          = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TW             = 21
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [WIDTH-1:0]     job_p,
    input  logic [WIDTH-1:0]     job_q,
    input  logic                 job_mode,
    input  logic [2*WIDTH-1:0]   job_msg,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic [1:0]           res_err,

    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_mode,
    output logic [2*WIDTH-1:0]   core_msg,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out
);

    typedef enum logic [2:0] {
        StIdle,
        StInvRst,
        StInvBlank,
        StInvWait,
        StExpRst,
        StExpBlank,
        StExpWait,
        StDone
    } state_e;

    localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT_CYCLES);

    state_e        state_q;
    logic [TW-1:0] tmo_q;
    logic          timed_out;

`ifdef RSA_ROUNDTRIP_CHECK_EN
    logic               pass2_q;
    logic [2*WIDTH-1:0] orig_msg_q;
`endif

    assign timed_out = (tmo_q == TmoLimit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= StIdle;
            tmo_q               <= '0;
            job_ready           <= 1'b1;
            res_valid           <= 1'b0;
            res_data            <= '0;
            res_err             <= 2'b00;
            core_p              <= '0;
            core_q              <= '0;
            core_mode           <= 1'b0;
            core_msg            <= '0;
            core_reset_inverter <= 1'b0;
            core_reset_mod_exp  <= 1'b0;
`ifdef RSA_ROUNDTRIP_CHECK_EN
            pass2_q             <= 1'b0;
            orig_msg_q          <= '0;
`endif
        end else begin
            // Reset pulses last exactly one cycle.
            core_reset_inverter <= 1'b0;
            core_reset_mod_exp  <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (job_valid) begin
                        core_p              <= job_p;
                        core_q              <= job_q;
                        core_mode           <= job_mode;
                        core_msg            <= job_msg;
                        job_ready           <= 1'b0;
                        core_reset_inverter <= 1'b1;
                        state_q             <= StInvRst;
`ifdef RSA_ROUNDTRIP_CHECK_EN
                        pass2_q             <= 1'b0;
                        orig_msg_q          <= job_msg;
`endif
                    end
                end

                StInvRst: begin
                    tmo_q   <= '0;
                    state_q <= StInvBlank;
                end

                // Finish may still be high from the previous job here; not sampled.
                StInvBlank: begin
                    tmo_q   <= tmo_q + TW'(1);
                    state_q <= StInvWait;
                end

                // A finish on the limit cycle wins over the timeout.
                StInvWait: begin
                    if (core_inverter_finish) begin
                        core_reset_mod_exp <= 1'b1;
                        state_q            <= StExpRst;
                    end else if (timed_out) begin
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 2'b01;
                        state_q   <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                StExpRst: begin
                    tmo_q   <= '0;
                    state_q <= StExpBlank;
                end

                StExpBlank: begin
                    tmo_q   <= tmo_q + TW'(1);
                    state_q <= StExpWait;
                end

                StExpWait: begin
                    if (core_mod_exp_finish) begin
`ifdef RSA_ROUNDTRIP_CHECK_EN
                        if (!core_mode) begin
                            // Encrypt pass done: feed the ciphertext back for decryption.
                            core_mode           <= 1'b1;
                            core_msg            <= core_msg_out;
                            pass2_q             <= 1'b1;
                            core_reset_inverter <= 1'b1;
                            state_q             <= StInvRst;
                        end else begin
                            res_valid <= 1'b1;
                            state_q   <= StDone;
                            if (pass2_q) begin
                                // core_msg holds the ciphertext from the first pass.
                                res_data <= core_msg;
                                res_err  <= (core_msg_out == orig_msg_q) ? 2'b00 : 2'b10;
                            end else begin
                                res_data <= core_msg_out;
                                res_err  <= 2'b00;
                            end
                        end
`else
                        res_valid <= 1'b1;
                        res_data  <= core_msg_out;
                        res_err   <= 2'b00;
                        state_q   <= StDone;
`endif
                    end else if (timed_out) begin
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 2'b01;
                        state_q   <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb_rsa_job_sequencer
//
// Directed bench for rsa_job_sequencer. A behavioural stub stands in for the RSA control
// core: inverter finish 5 cycles after its reset, mod_exp finish 8 cycles after its reset,
// both held high until the next reset. Cycle numbers below count rising edges after the
// accepting edge (cycle 1 = first cycle after acceptance).

module tb_rsa_job_sequencer;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned TMO   = 16;
    localparam int unsigned TW    = 5;

`ifdef RSA_ROUNDTRIP_CHECK_EN
    localparam int Passes   = 2;
    localparam int LatMain  = 35;
    localparam int LatStale = 39;
`else
    localparam int Passes   = 1;
    localparam int LatMain  = 18;
    localparam int LatStale = 20;
`endif

    localparam logic [WIDTH-1:0]   P1  = 128'd113680897410347;
    localparam logic [WIDTH-1:0]   Q1  = 128'd7999808077935876437321;
    localparam logic [2*WIDTH-1:0] Key = 256'hFEED;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               job_valid = 1'b0;
    logic               job_ready;
    logic [WIDTH-1:0]   job_p = '0;
    logic [WIDTH-1:0]   job_q = '0;
    logic               job_mode = 1'b0;
    logic [2*WIDTH-1:0] job_msg = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [2*WIDTH-1:0] res_data;
    logic [1:0]         res_err;
    logic [WIDTH-1:0]   core_p;
    logic [WIDTH-1:0]   core_q;
    logic               core_mode;
    logic [2*WIDTH-1:0] core_msg;
    logic               core_reset_inverter;
    logic               core_reset_mod_exp;
    logic               core_inverter_finish = 1'b0;
    logic               core_mod_exp_finish = 1'b0;
    logic [2*WIDTH-1:0] core_msg_out = '0;

    int n_tests = 0;
    int n_fail  = 0;

    rsa_job_sequencer #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TMO),
        .TW             (TW)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .job_valid            (job_valid),
        .job_ready            (job_ready),
        .job_p                (job_p),
        .job_q                (job_q),
        .job_mode             (job_mode),
        .job_msg              (job_msg),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_data             (res_data),
        .res_err              (res_err),
        .core_p               (core_p),
        .core_q               (core_q),
        .core_mode            (core_mode),
        .core_msg             (core_msg),
        .core_reset_inverter  (core_reset_inverter),
        .core_reset_mod_exp   (core_reset_mod_exp),
        .core_inverter_finish (core_inverter_finish),
        .core_mod_exp_finish  (core_mod_exp_finish),
        .core_msg_out         (core_msg_out)
    );

    always #5 clk = ~clk;

    // ---------------- control core stub ----------------
    logic slow_clear = 1'b0;  // finish clears one cycle late, so it is stale during BLANK
    logic inv_hold   = 1'b0;  // inverter never finishes
    logic rsa_mode   = 1'b0;  // real textbook RSA instead of XOR key
    logic corrupt    = 1'b0;  // flip bit 0 of decrypt output
    logic rst_inv_d  = 1'b0;
    logic rst_exp_d  = 1'b0;
    logic inv_busy   = 1'b0;
    logic exp_busy   = 1'b0;
    int   inv_cnt    = 0;
    int   exp_cnt    = 0;

    function automatic longint unsigned modexp(input longint unsigned b,
                                               input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r;
        longint unsigned x;
        longint unsigned k;
        r = 1;
        x = b % m;
        k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % m;
            x = (x * x) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] stub_fn(input logic [2*WIDTH-1:0] msg,
                                                   input logic mode,
                                                   input logic [WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0] q);
        longint unsigned n;
        longint unsigned r;
        if (!rsa_mode) return msg ^ Key;
        n = 64'(p[31:0]) * 64'(q[31:0]);
        r = modexp(64'(msg[63:0]), mode ? 64'd2753 : 64'd17, n);
        if (mode && corrupt) r = r ^ 64'd1;
        return 256'(r);
    endfunction

    always @(posedge clk) begin
        rst_inv_d <= core_reset_inverter;
        rst_exp_d <= core_reset_mod_exp;
        if (slow_clear ? rst_inv_d : core_reset_inverter) begin
            inv_cnt              <= 0;
            core_inverter_finish <= 1'b0;
            inv_busy             <= 1'b1;
        end else if (inv_busy && !inv_hold) begin
            inv_cnt <= inv_cnt + 1;
            if (inv_cnt + 1 == 5) begin
                core_inverter_finish <= 1'b1;
                inv_busy             <= 1'b0;
            end
        end
        if (slow_clear ? rst_exp_d : core_reset_mod_exp) begin
            exp_cnt             <= 0;
            core_mod_exp_finish <= 1'b0;
            exp_busy            <= 1'b1;
        end else if (exp_busy) begin
            exp_cnt <= exp_cnt + 1;
            if (exp_cnt + 1 == 8) begin
                core_mod_exp_finish <= 1'b1;
                core_msg_out        <= stub_fn(core_msg, core_mode, core_p, core_q);
                exp_busy            <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [2*WIDTH-1:0] got,
                         input logic [2*WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Offer one job, then watch up to 100 cycles for pulses and res_valid (res_ready low).
    task automatic run_job(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q,
                           input logic m, input logic [2*WIDTH-1:0] msg,
                           output int inv_n, output int inv_pulses,
                           output int exp_n, output int exp_pulses, output int done_n);
        inv_n = -1; inv_pulses = 0; exp_n = -1; exp_pulses = 0; done_n = -1;
        @(negedge clk);
        job_p = p; job_q = q; job_mode = m; job_msg = msg; job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (core_reset_inverter) begin
                inv_pulses++;
                if (inv_n < 0) inv_n = n;
            end
            if (core_reset_mod_exp) begin
                exp_pulses++;
                if (exp_n < 0) exp_n = n;
            end
            if (res_valid) begin
                done_n = n;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int inv_n, inv_p, exp_n, exp_p, done_n;
        logic ok;

        #1 reset_n = 1'b0;
        #1;
        check("rst_job_ready", job_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_core_p", core_p, 0);
        check("rst_core_msg", core_msg, 0);
        check("rst_pulses", {core_reset_inverter, core_reset_mod_exp}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Main job: pulse timing, latency and captured result.
        run_job(P1, Q1, 1'b0, 256'h49, inv_n, inv_p, exp_n, exp_p, done_n);
        check("t1_inv_pulse_cycle", inv_n, 1);
        check("t1_inv_pulses", inv_p, Passes);
        check("t1_exp_pulse_cycle", exp_n, 8);
        check("t1_exp_pulses", exp_p, Passes);
        check("t1_res_valid_cycle", done_n, LatMain);
        check("t1_res_data", res_data, 256'hFEA4);
        check("t1_res_err", res_err, 2'b00);
        check("t1_core_p", core_p, P1);
        check("t1_core_q", core_q, Q1);

        // Result held with res_ready low; a new job offer must be ignored.
        @(negedge clk);
        job_p = 128'd99; job_q = 128'd77; job_msg = 256'h55; job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t2_hold_valid", res_valid, 1);
            check("t2_hold_data", res_data, 256'hFEA4);
            check("t2_hold_job_ready", job_ready, 0);
            check("t2_hold_core_p", core_p, P1);
            check("t2_hold_no_pulse", core_reset_inverter, 0);
        end
        @(negedge clk);
        job_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_release_valid", res_valid, 0);
        check("t2_release_job_ready", job_ready, 1);
        @(negedge clk);
        res_ready = 1'b0;

        // Stale finish from the previous job must not shortcut the new job.
        slow_clear = 1'b1;
        run_job(128'd1009, 128'd2003, 1'b0, 256'h1234, inv_n, inv_p, exp_n, exp_p, done_n);
        check("t3_exp_pulse_cycle", exp_n, 9);
        check("t3_res_valid_cycle", done_n, LatStale);
        check("t3_res_data", res_data, 256'h1234 ^ Key);
        check("t3_res_err", res_err, 2'b00);
        consume();
        slow_clear = 1'b0;

        // Inverter never finishes: timeout abort, no mod_exp pulse.
        inv_hold = 1'b1;
        run_job(P1, Q1, 1'b1, 256'h77, inv_n, inv_p, exp_n, exp_p, done_n);
        check("t4_timeout_seen", done_n > 0, 1);
        check("t4_res_err", res_err, 2'b01);
        check("t4_res_data", res_data, 0);
        check("t4_no_exp_pulse", exp_p, 0);
        consume();
        inv_hold = 1'b0;

        // Reset during EXP_WAIT (cycle 12 of a single-pass job).
        @(negedge clk);
        job_p = P1; job_q = Q1; job_mode = 1'b1; job_msg = 256'h49; job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t5_job_ready", job_ready, 1);
        check("t5_res_valid", res_valid, 0);
        check("t5_res_data", res_data, 0);
        check("t5_core_p", core_p, 0);
        check("t5_core_mode", core_mode, 0);
        check("t5_core_msg", core_msg, 0);
        check("t5_pulses", {core_reset_inverter, core_reset_mod_exp}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (res_valid || core_reset_inverter || core_reset_mod_exp) ok = 1'b0;
        end
        check("t5_no_pending_result", ok, 1);
        check("t5_idle_after", job_ready, 1);

`ifdef RSA_ROUNDTRIP_CHECK_EN
        // Textbook RSA with n = 61*53, e = 17, d = 2753: 0x49^17 mod 3233 = 1486.
        rsa_mode = 1'b1;
        run_job(128'd61, 128'd53, 1'b0, 256'h49, inv_n, inv_p, exp_n, exp_p, done_n);
        check("t6_inv_pulses", inv_p, 2);
        check("t6_res_data", res_data, 256'd1486);
        check("t6_res_err", res_err, 2'b00);
        consume();
        corrupt = 1'b1;
        run_job(128'd61, 128'd53, 1'b0, 256'h49, inv_n, inv_p, exp_n, exp_p, done_n);
        check("t7_res_data", res_data, 256'd1486);
        check("t7_res_err", res_err, 2'b10);
        consume();
        corrupt = 1'b0;
        rsa_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
